// File: rtl/axi4_lite_wr_pkg.sv
// Shared types and constants for the AXI4-Lite write-command queue.
package axi4_lite_wr_pkg;

    // One-hot output-stage states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b01,
        ST_PRESENT = 2'b10
    } wr_state_e;

    localparam int DEFAULT_DEPTH = 16;
    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_DATA_W    = 32;
    localparam int CMD_W         = AXI_ADDR_W + AXI_DATA_W;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_wr_cmd_ram.sv
// Command storage array: synchronous write, asynchronous read.
module axi4_lite_wr_cmd_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_lite_wr_cmd_queue.sv
// In-order write-command queue feeding the AXI4-Lite write master.
// Optional counters wr_done_cnt/drop_cnt exist when AXI4_LITE_WR_CMD_QUEUE_CNT_EN is defined.
module axi4_lite_wr_cmd_queue
    import axi4_lite_wr_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
    output logic [31:0]            wr_done_cnt,
    output logic [15:0]            drop_cnt,
`endif
    output logic [1:0]             fsm_state
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CW    = ADDR_W + DATA_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // wr_valid, once high, is never withdrawn and its payload is frozen until wr_ready.
    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] arr_cnt, arr_cnt_d, level_d;
    logic             in_ready_q;
    logic [CW-1:0]    ram_rdata;
    logic             push, pop, arr_empty;
    logic             load_arr, load_in, arr_we;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q == ST_PRESENT) && wr_ready;
    assign arr_empty = (arr_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_arr = 1'b0;
        load_in  = 1'b0;
        arr_we   = 1'b0;
        if (flush) begin
            // A presented head survives flush unless it completes this cycle.
            if (pop) begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_IDLE || pop) begin
            if (!arr_empty) begin
                load_arr = 1'b1;
                arr_we   = push;
                state_d  = ST_PRESENT;
            end else if (push) begin
                // Empty array: the command goes straight into the output registers.
                load_in = 1'b1;
                state_d = ST_PRESENT;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            arr_we = push;
        end
    end

    always_comb begin
        if (flush) begin
            arr_cnt_d = '0;
        end else begin
            arr_cnt_d = arr_cnt + LVL_W'(arr_we) - LVL_W'(load_arr);
        end
        level_d = arr_cnt_d + LVL_W'(state_d == ST_PRESENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            arr_cnt    <= '0;
            in_ready_q <= 1'b1;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            arr_cnt    <= arr_cnt_d;
            in_ready_q <= (level_d != LVL_FULL);
            if (arr_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (load_arr) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load_arr) begin
                {wr_addr, wr_data} <= ram_rdata;
            end else if (load_in) begin
                {wr_addr, wr_data} <= {in_addr, in_data};
            end
        end
    end

    axi4_lite_wr_cmd_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CW),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (arr_we),
        .waddr (wr_ptr),
        .wdata ({in_addr, in_data}),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign level     = arr_cnt + LVL_W'(state_q == ST_PRESENT);
    assign empty     = (level == '0);
    assign full      = (level == LVL_FULL);
    assign in_ready  = in_ready_q;
    assign wr_valid  = (state_q == ST_PRESENT);
    assign fsm_state = state_q;

`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
    logic [16:0] drop_sum;

    // Flush drops every array entry plus a push landing in the same cycle.
    assign drop_sum = 17'(drop_cnt) + 17'(arr_cnt) + 17'(push);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_done_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (pop) begin
                wr_done_cnt <= wr_done_cnt + 32'd1;
            end
            if (flush) begin
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi4_lite_wr_cmd_queue.sv
// Scoreboard bench for axi4_lite_wr_cmd_queue; counter checks when AXI4_LITE_WR_CMD_QUEUE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_axi4_lite_wr_cmd_queue;

    localparam int DEPTH = 16;
    localparam int CW    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic [1:0]  fsm_state;
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
    logic [31:0] wr_done_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    axi4_lite_wr_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
        .wr_done_cnt (wr_done_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .fsm_state   (fsm_state)
    );

    logic [CW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: order check on every handshake, payload stability during stalls.
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_cmd   = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {wr_valid, wr_addr, wr_data}, {1'b1, prev_cmd});
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_wr: got %0h expected none", {wr_addr, wr_data});
                end else begin
                    check("wr_order", {wr_addr, wr_data}, exp_q.pop_front());
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_cmd   = {wr_addr, wr_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        for (int n = 0; n < 100; n++) begin
            acc = in_ready;
            if (acc) exp_q.push_back({a, d});
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_valid) && n < 300) begin
            tick();
            n++;
        end
        check(name, (exp_q.size() == 0 && !wr_valid), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_level", level, 5'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_cmd", {wr_addr, wr_data}, 64'd0);
        check("rst_state", fsm_state, 2'b01);
        rst = 1'b0;
        tick();

        // Single command: presented the cycle after the push, for one cycle.
        wr_ready = 1'b1;
        push_cmd(32'h0000_1000, 32'hDEAD_BEEF);
        check("single_valid", wr_valid, 1'b1);
        check("single_level", level, 5'd1);
        check("single_cmd", {wr_addr, wr_data}, {32'h0000_1000, 32'hDEAD_BEEF});
        tick();
        check("single_valid_drop", wr_valid, 1'b0);
        check("single_level0", level, 5'd0);
        check("single_empty", empty, 1'b1);

        // Fill to full, hold off a 17th command, then drain back-to-back.
        wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_cmd(32'h100 + 32'(i * 4), 32'(i));
        check("fill_full", full, 1'b1);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_level", level, 5'd16);
        in_valid = 1'b1;
        in_addr  = 32'hBAD;
        in_data  = 32'hBAD;
        repeat (3) tick();
        check("held_in_ready", in_ready, 1'b0);
        check("held_level", level, 5'd16);
        in_valid = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("b2b_valid", wr_valid, 1'b1);
            tick();
        end
        check("drain_valid", wr_valid, 1'b0);
        check("drain_empty", empty, 1'b1);
        check("drain_in_ready", in_ready, 1'b1);

        // Random backpressure while commands stream in.
        fork
            begin
                for (int i = 0; i < 12; i++) push_cmd(32'h3000 + 32'(i * 8), 32'hA5A5_0000 + 32'(i));
            end
            begin
                repeat (80) begin
                    wr_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                wr_ready = 1'b1;
            end
        join
        wait_drain("drain_bp");

        // Sustained push/pop at full rate across pointer wraps.
        wr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_cmd(32'h4000 + 32'(i), 32'(i) ^ 32'hFFFF_0000);
            check("wrap_level_le2", (level <= 5'd2), 1'b1);
        end
        wait_drain("drain_wrap");

        // Flush with a presented head held off by the master.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(32'h5000 + 32'(i), 32'h50 + 32'(i));
        check("pre_flush_level", level, 5'd5);
        flush = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        flush = 1'b0;
        check("flush_level", level, 5'd1);
        check("flush_head_valid", wr_valid, 1'b1);
        check("flush_head_cmd", {wr_addr, wr_data}, {32'h5000, 32'h50});
        check("flush_in_ready", in_ready, 1'b1);
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
        check("flush_drop_cnt", drop_cnt, 16'd4);
`endif
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        check("flush_after_empty", empty, 1'b1);
        check("flush_after_valid", wr_valid, 1'b0);
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
        check("flush_done_cnt", wr_done_cnt, 32'd1);
`endif

        // Push coinciding with flush is accepted and discarded.
        in_valid = 1'b1;
        in_addr  = 32'hBAD0;
        in_data  = 32'h0BAD;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fpush_valid", wr_valid, 1'b0);
        check("fpush_level", level, 5'd0);
        check("fpush_in_ready", in_ready, 1'b1);
        tick();
        check("fpush_still_idle", wr_valid, 1'b0);
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
        check("fpush_drop_cnt", drop_cnt, 16'd5);
`endif

        // Flush together with wr_ready: head completes, rest dropped.
        for (int i = 0; i < 3; i++) push_cmd(32'h6000 + 32'(i), 32'h60 + 32'(i));
        flush    = 1'b1;
        wr_ready = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        flush    = 1'b0;
        wr_ready = 1'b0;
        check("fdone_empty", empty, 1'b1);
        check("fdone_valid", wr_valid, 1'b0);
        check("fdone_scoreboard", exp_q.size(), 0);
`ifdef AXI4_LITE_WR_CMD_QUEUE_CNT_EN
        check("fdone_done_cnt", wr_done_cnt, 32'd2);
        check("fdone_drop_cnt", drop_cnt, 16'd7);
`endif

        // Reset mid-operation discards everything, including the head.
        for (int i = 0; i < 7; i++) push_cmd(32'h7000 + 32'(i), 32'h70 + 32'(i));
        check("mid_level", level, 5'd7);
        check("mid_valid", wr_valid, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("mid_rst_valid", wr_valid, 1'b0);
        check("mid_rst_level", level, 5'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        wr_ready = 1'b1;
        push_cmd(32'h20, 32'h55);
        check("post_rst_cmd", {wr_valid, wr_addr, wr_data}, {1'b1, 32'h20, 32'h55});
        wait_drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
